// File: rtl/phys_reg_free_list.sv
// rtl/phys_reg_free_list.sv - rename-stage free list of physical register tags
//
// Circular list of free physical tags with a speculative head (allocation),
// a committed head (retirement) and a tail (tags returned at commit).
// A flush rewinds the speculative head to the committed head in one cycle.
//
// Ports:
//   clk, sync_rst_n  clock and synchronous active-low reset
//   clk_en           global enable; no state change while low
//   alloc_req        per-port allocation request mask
//   alloc_gnt        all requested tags granted this cycle (all-or-nothing)
//   alloc_tag        tag for each requesting port, compacted in port order
//   rel_valid        per-port release valid
//   rel_tag          tags being returned, appended at tail in port order
//   commit_cnt       number of allocations retired this cycle
//   recover          flush: speculative head <= committed head (+ commit)
//   free_count       tail minus speculative head
//   empty            free_count == 0
module phys_reg_free_list #(
  parameter int PHYS_COUNT    = 64,
  parameter int ARCH_COUNT    = 32,
  parameter int TAG_WIDTH     = $clog2(PHYS_COUNT),
  parameter int DEPTH         = PHYS_COUNT - ARCH_COUNT,
  parameter int PTR_WIDTH     = $clog2(DEPTH) + 1,
  parameter int ALLOC_PORTS   = 2,
  parameter int RELEASE_PORTS = 2,
  parameter int CNT_WIDTH     = $clog2(ALLOC_PORTS + 1)
) (
  input  logic                 clk,
  input  logic                 sync_rst_n,
  input  logic                 clk_en,
  input  logic [ALLOC_PORTS-1:0]   alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag [ALLOC_PORTS],
  input  logic [RELEASE_PORTS-1:0] rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag [RELEASE_PORTS],
  input  logic [CNT_WIDTH-1:0] commit_cnt,
  input  logic                 recover,
  output logic [PTR_WIDTH-1:0] free_count,
  output logic                 empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [TAG_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] spec_head_q, spec_head_d;
  logic [PTR_WIDTH-1:0] cmt_head_q, cmt_head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;

  logic [PTR_WIDTH-1:0] n_req, n_rel;
  logic [PTR_WIDTH-1:0] alloc_off [ALLOC_PORTS];
  logic [PTR_WIDTH-1:0] rel_off [RELEASE_PORTS];
  logic [PTR_WIDTH-1:0] occ_next, spec_lead;

  // Running popcounts give each active port its compacted slot offset.
  always_comb begin
    n_req = '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_off[i] = n_req;
      n_req        = n_req + PTR_WIDTH'(alloc_req[i]);
    end
    n_rel = '0;
    for (int j = 0; j < RELEASE_PORTS; j++) begin
      rel_off[j] = n_rel;
      n_rel      = n_rel + PTR_WIDTH'(rel_valid[j]);
    end
  end

  always_comb begin
    free_count = tail_q - spec_head_q;
    empty      = (free_count == '0);
    alloc_gnt  = clk_en & sync_rst_n & ~recover & (n_req != '0) & (n_req <= free_count);
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      alloc_tag[i] = mem_q[IDX_W'(spec_head_q + alloc_off[i])];
    end
  end

  // Commit is applied before recover so a flush lands on the retired boundary.
  always_comb begin
    cmt_head_d = cmt_head_q + PTR_WIDTH'(commit_cnt);
    tail_d     = tail_q + n_rel;
    if (recover) begin
      spec_head_d = cmt_head_d;
    end else if (alloc_gnt) begin
      spec_head_d = spec_head_q + n_req;
    end else begin
      spec_head_d = spec_head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_WIDTH'(ARCH_COUNT + i);
      end
      spec_head_q <= '0;
      cmt_head_q  <= '0;
      tail_q      <= PTR_WIDTH'(DEPTH);
    end else if (clk_en) begin
      for (int j = 0; j < RELEASE_PORTS; j++) begin
        if (rel_valid[j]) begin
          mem_q[IDX_W'(tail_q + rel_off[j])] <= rel_tag[j];
        end
      end
      spec_head_q <= spec_head_d;
      cmt_head_q  <= cmt_head_d;
      tail_q      <= tail_d;
    end
  end

  // Entries between cmt_head and tail are live (free or awaiting commit);
  // releases must never overwrite an uncommitted slot.
  assign occ_next  = tail_q + n_rel - cmt_head_q;
  assign spec_lead = spec_head_q - cmt_head_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!sync_rst_n)
    clk_en |-> (occ_next <= PTR_WIDTH'(DEPTH)));

  a_commit_in_range: assert property (@(posedge clk) disable iff (!sync_rst_n)
    clk_en |-> (PTR_WIDTH'(commit_cnt) <= spec_lead));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb/tb_phys_reg_free_list.sv - scoreboard bench for phys_reg_free_list
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       sync_rst_n, clk_en, recover, alloc_gnt, empty;
  logic [1:0] alloc_req, rel_valid, commit_cnt;
  logic [5:0] alloc_tag [2];
  logic [5:0] rel_tag [2];
  logic [5:0] free_count;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk       (clk),
    .sync_rst_n(sync_rst_n),
    .clk_en    (clk_en),
    .alloc_req (alloc_req),
    .alloc_gnt (alloc_gnt),
    .alloc_tag (alloc_tag),
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .commit_cnt(commit_cnt),
    .recover   (recover),
    .free_count(free_count),
    .empty     (empty)
  );

  typedef struct {
    string      nm;
    bit         gnt;
    bit [1:0]   req;
    logic [5:0] t0;
    logic [5:0] t1;
    logic [5:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.nm, "gnt", 32'(alloc_gnt), 32'(mon_e.gnt));
      chk(mon_e.nm, "free_count", 32'(free_count), 32'(mon_e.fc));
      chk(mon_e.nm, "empty", 32'(empty), 32'(mon_e.fc == 6'd0));
      if (mon_e.gnt && mon_e.req[0]) chk(mon_e.nm, "tag0", 32'(alloc_tag[0]), 32'(mon_e.t0));
      if (mon_e.gnt && mon_e.req[1]) chk(mon_e.nm, "tag1", 32'(alloc_tag[1]), 32'(mon_e.t1));
    end
  end

  task automatic step(input string nm, input logic [1:0] req, input logic [1:0] rv,
                      input logic [5:0] r0, input logic [5:0] r1, input logic [1:0] cc,
                      input logic rec, input logic en, input bit eg,
                      input logic [5:0] et0, input logic [5:0] et1, input logic [5:0] efc);
    exp_t e;
    alloc_req  = req;
    rel_valid  = rv;
    rel_tag[0] = r0;
    rel_tag[1] = r1;
    commit_cnt = cc;
    recover    = rec;
    clk_en     = en;
    e.nm = nm; e.gnt = eg; e.req = req; e.t0 = et0; e.t1 = et1; e.fc = efc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync_rst_n = 1'b0;
    alloc_req = '0; rel_valid = '0; commit_cnt = '0; recover = 1'b0; clk_en = 1'b1;
    rel_tag[0] = '0; rel_tag[1] = '0;
    @(posedge clk);
    #1;
    // Still in reset: state is initialised, grant is blocked.
    step("reset", 2'b11, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 6'd32);
    sync_rst_n = 1'b1;
  endtask

  logic [5:0] t0, r0, fc;
  logic [1:0] rv, cc;

  initial begin
    do_reset();

    // Port 1 alone gets the head tag; then port 0 gets the next.
    step("c_p1", 2'b10, 0, 0, 0, 0, 0, 1, 1, 0, 6'd32, 6'd32);
    step("c_p0", 2'b01, 0, 0, 0, 0, 0, 1, 1, 6'd33, 0, 6'd31);
    step("c_idle", 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd30);

    // Drain all 32 tags two at a time, committing one cycle behind.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      t0 = 6'(32 + 2 * k);
      cc = (k >= 1) ? 2'd2 : 2'd0;
      step("a_drain", 2'b11, 0, 0, 0, cc, 0, 1, 1, t0, t0 + 6'd1, 6'(32 - 2 * k));
    end
    step("a_empty11", 2'b11, 0, 0, 0, 2, 0, 1, 0, 0, 0, 6'd0);
    step("a_empty01", 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd0);

    // Release 5 and 9; allocatable next cycle, in port order.
    step("b_rel", 2'b00, 2'b11, 6'd5, 6'd9, 0, 0, 1, 0, 0, 0, 6'd0);
    step("b_alloc", 2'b11, 0, 0, 0, 0, 0, 1, 1, 6'd5, 6'd9, 6'd2);

    // Single free tag released on port 1 only; double request refused.
    step("d_rel", 2'b00, 2'b10, 6'd50, 6'd7, 2, 0, 1, 0, 0, 0, 6'd0);
    step("d_ref1", 2'b11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd1);
    step("d_ref2", 2'b11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd1);
    step("d_gnt", 2'b01, 0, 0, 0, 0, 0, 1, 1, 6'd7, 0, 6'd1);
    step("d_after", 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd0);

    // Allocate 6, commit 2, recover with commit 1 -> 29 free, next is 35.
    do_reset();
    step("e_a0", 2'b11, 0, 0, 0, 0, 0, 1, 1, 6'd32, 6'd33, 6'd32);
    step("e_a1", 2'b11, 0, 0, 0, 0, 0, 1, 1, 6'd34, 6'd35, 6'd30);
    step("e_a2", 2'b11, 0, 0, 0, 0, 0, 1, 1, 6'd36, 6'd37, 6'd28);
    step("e_cmt", 2'b00, 0, 0, 0, 2, 0, 1, 0, 0, 0, 6'd26);
    step("e_rec", 2'b11, 0, 0, 0, 1, 1, 1, 0, 0, 0, 6'd26);
    step("e_post", 2'b01, 0, 0, 0, 0, 0, 1, 1, 6'd35, 0, 6'd29);

    // Steady-state alloc/commit/release; tail wraps the pointer space.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k == 10) begin
        step("f_freeze", 2'b11, 2'b11, 6'd60, 6'd61, 2, 1, 0, 0, 0, 0, 6'd28);
      end
      rv = (k >= 2) ? 2'b11 : 2'b00;
      r0 = 6'(2 * (k - 2));
      cc = (k >= 1) ? 2'd2 : 2'd0;
      fc = (k == 0) ? 6'd32 : (k == 1) ? 6'd30 : 6'd28;
      t0 = (k < 16) ? 6'(32 + 2 * k) : 6'(2 * (k - 16));
      step("f_wrap", 2'b11, rv, r0, r0 + 6'd1, cc, 0, 1, 1, t0, t0 + 6'd1, fc);
    end
    step("f_end", 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'd28);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
